// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: state encoding and counter width.
package mem_access_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RD   = ST_RD,
        S_WR   = ST_WR,
        S_DONE = ST_DONE
    } state_e;

    // IDLE and DONE both accept new requests and register loads.
    function automatic logic is_accepting(input state_e s);
        return (s == S_IDLE) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/mem_access_unit_lat_counter.sv
// Loadable down-counter; zero is registered and always reflects the held count.
module lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
            zero  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            zero  <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR owner that sequences reads and writes to a synchronous RAM with
// a configurable read latency and a busy/done handshake.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              write,
    output logic [DATA_W-1:0] mdr_q,
    output logic [ADDR_W-1:0] mar_q,
    output logic              busy,
    output logic              done,
    output logic              conflict,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e state_q;
    logic   cnt_load;
    logic   cnt_en;
    logic   cnt_zero;

    assign cnt_load  = is_accepting(state_q) && Read && !write;
    assign cnt_en    = (state_q == S_RD);
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

    lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Outputs are registered from the state being entered, so they align with it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            conflict <= 1'b0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            busy     <= 1'b0;
            done     <= 1'b0;
            conflict <= 1'b0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (MARin) begin
                        mar_q <= bus_in[ADDR_W-1:0];
                    end
                    if (MDRin) begin
                        mdr_q <= bus_in;
                    end
                    // A simultaneous read and write resolves to the write.
                    if (write) begin
                        state_q  <= S_WR;
                        busy     <= 1'b1;
                        mem_we   <= 1'b1;
                        conflict <= Read;
                    end else if (Read) begin
                        state_q <= S_RD;
                        busy    <= 1'b1;
                        mem_re  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (cnt_zero) begin
                        mdr_q   <= mem_rdata;
                        state_q <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        busy   <= 1'b1;
                        mem_re <= 1'b1;
                    end
                end
                S_WR: begin
                    state_q <= S_DONE;
                    done    <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the fixed MAR/MDR pair in the single-bus CPU datapath.
- Owns the address register (MAR) and the data register (MDR).
- Sequences read and write transactions to synchronous RAM through a small FSM:
  - configurable read latency
  - busy/done handshake toward the control unit
  - conflict detection when read and write are requested together

Parameters:
- DATA_W, 32, width of bus, MDR and memory data.
- ADDR_W, 9, width of MAR and memory address; MAR loads from bus_in[ADDR_W-1:0].
- MEM_LAT, 1, read latency in cycles from first mem_re cycle to capture; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  value driven on the datapath bus (busMuxOut).
- MARin  in  1  load MAR from bus_in.
- MDRin  in  1  load MDR from bus_in.
- Read  in  1  request a memory read into MDR.
- write  in  1  request a memory write of MDR.
- mdr_q  out  DATA_W  MDR contents (BusMuxInMDR source).
- mar_q  out  ADDR_W  MAR contents.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- conflict  out  1  one-cycle pulse when Read and write are sampled together.
- mem_addr  out  ADDR_W  RAM address; always equals mar_q.
- mem_wdata  out  DATA_W  RAM write data; always equals mdr_q.
- mem_re  out  1  RAM read enable.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Clock and reset:
  - One clock: Clock.
  - Reset is synchronous and active-high.
  - Reset (including mid-transaction) forces state IDLE, MAR=0, MDR=0, counter=0.
  - All outputs are 0 in the cycle after reset, except mem_addr and mem_wdata, which follow MAR and MDR (0).
  - An aborted read or write never updates MDR.
- States: IDLE, RD, WR, DONE; binary encoded.
- IDLE and DONE (accepting states):
  - Read=1, write=0: go to RD and load cnt=MEM_LAT-1.
  - write=1, Read=0: go to WR.
  - Read=1 and write=1: write wins, go to WR; conflict=1 in the following cycle only.
  - Neither: IDLE stays IDLE; DONE goes to IDLE.
  - DONE accepting requests gives back-to-back transactions with no idle gap.
- RD:
  - mem_re=1 and busy=1 every RD cycle.
  - cnt decrements each cycle.
  - When cnt==0: MDR <= mem_rdata at that edge, then go to DONE.
  - Total RD cycles = MEM_LAT.
- WR:
  - Lasts exactly one cycle with mem_we=1 and busy=1.
  - Then go to DONE.
- DONE: done=1, busy=0 for one cycle.
- Latency:
  - Request sampled at edge k.
  - Read: data visible on mdr_q and done=1 in cycle k+MEM_LAT+1.
  - Write: done=1 in cycle k+2.
- Register loads:
  - MARin is honoured only in IDLE/DONE; ignored while busy so the address is stable.
  - MDRin is honoured only in IDLE/DONE; ignored while busy.
  - MARin together with a request in the same cycle: the new MAR value is used by that transaction, since MAR loads at the same edge as the state change.
  - MDRin together with write in the same cycle: the new MDR value is written.
- Requests while busy are dropped silently; they are not queued.
- mem_re and mem_we are never high in the same cycle.

Decomposition:
- Shared package (mem_access_pkg):
  - state encoding localparams ST_IDLE=0, ST_RD=1, ST_WR=2, ST_DONE=3
  - counter width localparam CNT_W=4
- One natural sub-module: lat_counter.
  - Loadable down-counter with a zero flag.
  - Parameters: CNT_W.
  - Ports: Clock, Reset, load, load_val, en, zero.

Test Plan:
1. Reset mid-read: issue Read with MEM_LAT=3, assert Reset in RD -> next cycle state IDLE, busy=0, mdr_q=0, mem_re=0.
2. Read, MEM_LAT=1:
   - Drive bus_in=0x0000_0015 with MARin, RAM[0x15]=0xDEAD_BEEF, Read one cycle.
   - Expect mem_re high for 1 cycle at mem_addr=0x015.
   - Expect mdr_q=0xDEADBEEF with done=1 two cycles after Read.
3. Read, MEM_LAT=4: same stimulus -> busy high exactly 4 cycles, done in cycle k+5, MARin=0x1FF during busy ignored (mar_q stays 0x015).
4. Write: MARin with 0x020, MDRin with 0x1234_5678, write -> mem_we high 1 cycle with mem_addr=0x020, mem_wdata=0x12345678; done at k+2; RAM[0x20] reads back 0x12345678.
5. Conflict: Read=1 and write=1 in the same cycle -> conflict=1 for one cycle, a WR transaction occurs, mem_re never asserts.
6. Back-to-back: assert write in the DONE cycle of a prior read -> WR in the next cycle with no IDLE gap; a Read pulse during WR is dropped (no mem_re follows).
